// File: rtl/vdg_pkg.sv
// Shared video-display-generator definitions: mode encodings, colour codes, byte payload.
package vdg_pkg;

  localparam int unsigned SLOTS    = 8;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ATTR_W   = 4;
  localparam int unsigned COLOUR_W = 4;
  localparam int unsigned COUNT_W  = 4;
  localparam int unsigned SLOT_W   = 3;

  typedef enum logic [1:0] {
    MODE_ALPHA = 2'd0,
    MODE_SG    = 2'd1,
    MODE_CG    = 2'd2,
    MODE_RG    = 2'd3
  } mode_e;

  localparam logic [COLOUR_W-1:0] BLACK    = 4'd0;
  localparam logic [COLOUR_W-1:0] GREEN    = 4'd1;
  localparam logic [COLOUR_W-1:0] YELLOW   = 4'd2;
  localparam logic [COLOUR_W-1:0] BLUE     = 4'd3;
  localparam logic [COLOUR_W-1:0] RED      = 4'd4;
  localparam logic [COLOUR_W-1:0] BUFF     = 4'd5;
  localparam logic [COLOUR_W-1:0] CYAN     = 4'd6;
  localparam logic [COLOUR_W-1:0] MAGENTA  = 4'd7;
  localparam logic [COLOUR_W-1:0] ORANGE   = 4'd8;
  localparam logic [COLOUR_W-1:0] DKGREEN  = 4'd10;
  localparam logic [COLOUR_W-1:0] DKORANGE = 4'd11;

  // One fetched video byte together with its attribute nibble.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ATTR_W-1:0] attr;
  } vbyte_t;

endpackage

// File: rtl/vdg_pixel_decode.sv
// Combinational pixel decode: mode, current bit/pair and attributes to a colour code.
module vdg_pixel_decode
  import vdg_pkg::*;
(
  input  mode_e               mode_i,
  input  logic                css_i,
  input  logic [ATTR_W-1:0]   attr_i,
  input  logic                bit_i,
  input  logic [1:0]          pair_i,
  output logic [COLOUR_W-1:0] colour_o
);

  // Per-mode colour selection.
  always_comb begin
    colour_o = BLACK;
    case (mode_i)
      MODE_ALPHA: begin
        if (bit_i ^ attr_i[3]) colour_o = css_i ? ORANGE : GREEN;
        else                   colour_o = css_i ? DKORANGE : DKGREEN;
      end
      MODE_SG: begin
        if (bit_i) colour_o = COLOUR_W'(attr_i[2:0]) + GREEN;
      end
      MODE_CG: begin
        colour_o = COLOUR_W'(pair_i) + (css_i ? BUFF : GREEN);
      end
      MODE_RG: begin
        if (bit_i) colour_o = css_i ? BUFF : GREEN;
      end
      default: colour_o = BLACK;
    endcase
  end

endmodule

// File: rtl/vdg_pixel_shifter.sv
// Serialises one held video byte per 8 pixel slots into a colour code and select strobe.
module vdg_pixel_shifter
  import vdg_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic                PixEn,
  input  logic                Active,
  input  logic [DATA_W-1:0]   DataIn,
  input  logic [ATTR_W-1:0]   AttrIn,
  input  logic                DataStb,
  input  logic [1:0]          Mode,
  input  logic                Css,
  input  logic                ClrFlags,
  output logic                HoldFull,
  output logic [COLOUR_W-1:0] Colour,
  output logic                Sel,
  output logic                Underrun,
  output logic                Overrun
);

  vbyte_t               hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  vbyte_t               shift_q, shift_d;
  mode_e                sh_mode_q, sh_mode_d;
  logic                 sh_css_q, sh_css_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [COLOUR_W-1:0]  colour_q, colour_d;
  logic                 sel_q, sel_d;
  logic                 underrun_q, underrun_d;
  logic                 overrun_q, overrun_d;

  logic                 load_point_c;
  logic                 load_c;
  logic                 underrun_set_c;
  logic                 overrun_set_c;
  vbyte_t               dec_src_c;
  mode_e                dec_mode_c;
  logic                 dec_css_c;
  logic [SLOT_W-1:0]    slot_c;
  logic [SLOT_W-1:0]    pair_idx_c;
  logic                 dec_bit_c;
  logic [1:0]           dec_pair_c;
  logic [COLOUR_W-1:0]  dec_colour_c;

  // Load and error events for this cycle.
  assign load_point_c   = PixEn && Active && (count_q == COUNT_W'(0));
  assign load_c         = load_point_c && hold_full_q;
  assign underrun_set_c = load_point_c && !hold_full_q;
  assign overrun_set_c  = DataStb && hold_full_q && !load_c;

  // On a load the decoder looks straight at the holding register so slot 0 needs no extra cycle.
  assign dec_src_c  = load_c ? hold_q : shift_q;
  assign dec_mode_c = load_c ? mode_e'(Mode) : sh_mode_q;
  assign dec_css_c  = load_c ? Css : sh_css_q;
  assign slot_c     = load_c ? SLOT_W'(0) : SLOT_W'(COUNT_W'(SLOTS) - count_q);
  assign pair_idx_c = {slot_c[2:1], 1'b0};
  assign dec_bit_c  = dec_src_c.data[SLOT_W'(7) - slot_c];
  assign dec_pair_c = {dec_src_c.data[SLOT_W'(7) - pair_idx_c],
                       dec_src_c.data[SLOT_W'(6) - pair_idx_c]};

  vdg_pixel_decode u_decode (
    .mode_i   (dec_mode_c),
    .css_i    (dec_css_c),
    .attr_i   (dec_src_c.attr),
    .bit_i    (dec_bit_c),
    .pair_i   (dec_pair_c),
    .colour_o (dec_colour_c)
  );

  // Next-state logic for holding register, shifter, counter, outputs and sticky flags.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    sh_mode_d   = sh_mode_q;
    sh_css_d    = sh_css_q;
    count_d     = count_q;
    colour_d    = colour_q;
    sel_d       = sel_q;

    if (PixEn) begin
      if (!Active) begin
        colour_d = BLACK;
        sel_d    = 1'b0;
        count_d  = COUNT_W'(0);
        shift_d  = '0;
      end else if (count_q == COUNT_W'(0)) begin
        if (hold_full_q) begin
          shift_d   = hold_q;
          sh_mode_d = mode_e'(Mode);
          sh_css_d  = Css;
          count_d   = COUNT_W'(SLOTS - 1);
          colour_d  = dec_colour_c;
          sel_d     = 1'b1;
        end else begin
          colour_d = BLACK;
          sel_d    = 1'b0;
        end
      end else begin
        count_d  = count_q - COUNT_W'(1);
        colour_d = dec_colour_c;
        sel_d    = 1'b1;
      end
    end

    // A strobe always refills the holding register, even on the cycle it is drained.
    if (DataStb) begin
      hold_d      = '{data: DataIn, attr: AttrIn};
      hold_full_d = 1'b1;
    end else if (load_c) begin
      hold_full_d = 1'b0;
    end

    underrun_d = underrun_set_c || (underrun_q && !ClrFlags);
    overrun_d  = overrun_set_c  || (overrun_q  && !ClrFlags);
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      sh_mode_q   <= MODE_ALPHA;
      sh_css_q    <= 1'b0;
      count_q     <= '0;
      colour_q    <= BLACK;
      sel_q       <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      sh_mode_q   <= sh_mode_d;
      sh_css_q    <= sh_css_d;
      count_q     <= count_d;
      colour_q    <= colour_d;
      sel_q       <= sel_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
    end
  end

  assign HoldFull = hold_full_q;
  assign Colour   = colour_q;
  assign Sel      = sel_q;
  assign Underrun = underrun_q;
  assign Overrun  = overrun_q;

endmodule
